// File: rtl/alu_seq_pkg.sv
// Shared op-code and state definitions for the sequential ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_adder.sv
// WIDTH-bit ripple adder exposing carry out and the carry into the MSB (for signed overflow).
module alu_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_c_o,
  output logic             cout_c_o,
  output logic             c_msb_c_o
);

  logic [WIDTH-1:0] lo_sum;
  logic [1:0]       hi_sum;

  // Split at the MSB so the carry into it is visible.
  always_comb begin
    lo_sum    = WIDTH'(a_i[WIDTH-2:0]) + WIDTH'(b_i[WIDTH-2:0]) + WIDTH'(cin_i);
    c_msb_c_o = lo_sum[WIDTH-1];
    hi_sum    = 2'(a_i[WIDTH-1]) + 2'(b_i[WIDTH-1]) + 2'(c_msb_c_o);
    sum_c_o   = {hi_sum[0], lo_sum[WIDTH-2:0]};
    cout_c_o  = hi_sum[1];
  end

endmodule : alu_adder

// File: rtl/alu_seq.sv
// Accumulator ALU with single-cycle ops and a WIDTH-cycle shift-add unsigned multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cin,
  input  logic [2:0]       op,
  input  logic             lock_in_data,
  input  logic             lock_out_data,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_hi,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, mcand_q, mpl_q;
  logic [PW-1:0]    prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_data_q, out_hi_q;
  logic             cout_q, zero_q, ovf_q, busy_q, done_q;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout, add_cmsb;
  logic [WIDTH-1:0] res_d;
  logic             res_cout_d, res_ovf_d;
  logic [PW-1:0]    prod_d;
  logic             mul_last;

  // One adder serves ADD/SUB in IDLE and the partial-product add in MUL.
  always_comb begin
    add_a   = a_q;
    add_b   = in_data;
    add_cin = 1'b0;
    if (state_q == ST_MUL) begin
      add_a = prod_q[PW-1:WIDTH];
      add_b = mpl_q[0] ? mcand_q : '0;
    end else if (op == OP_SUB) begin
      add_b   = ~in_data;
      add_cin = 1'b1;
    end else if (op == OP_ADD) begin
      add_cin = cin;
    end
  end

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i       (add_a),
    .b_i       (add_b),
    .cin_i     (add_cin),
    .sum_c_o   (add_sum),
    .cout_c_o  (add_cout),
    .c_msb_c_o (add_cmsb)
  );

  always_comb begin
    res_d      = add_sum;
    res_cout_d = 1'b0;
    res_ovf_d  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res_cout_d = add_cout;
        res_ovf_d  = add_cout ^ add_cmsb;
      end
      OP_AND: res_d = a_q & in_data;
      OP_OR:  res_d = a_q | in_data;
      OP_XOR: res_d = a_q ^ in_data;
      OP_SHL: begin
        res_d      = {a_q[WIDTH-2:0], cin};
        res_cout_d = a_q[WIDTH-1];
      end
      OP_SHR: begin
        res_d      = {cin, a_q[WIDTH-1:1]};
        res_cout_d = a_q[0];
      end
      default: res_d = add_sum;
    endcase
  end

  // Add into the upper half, then shift the whole product right with the carry.
  assign prod_d   = {add_cout, add_sum, prod_q[WIDTH-1:1]};
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      mcand_q    <= '0;
      mpl_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_hi_q   <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lock_in_data) a_q <= in_data;
          if (lock_out_data) begin
            if (op == OP_MUL) begin
              mcand_q <= a_q;
              mpl_q   <= in_data;
              prod_q  <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_MUL;
            end else begin
              out_data_q <= res_d;
              out_hi_q   <= '0;
              cout_q     <= res_cout_d;
              zero_q     <= (res_d == '0);
              ovf_q      <= res_ovf_d;
            end
          end
        end
        ST_MUL: begin
          prod_q <= prod_d;
          mpl_q  <= mpl_q >> 1;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            out_data_q <= prod_d[WIDTH-1:0];
            out_hi_q   <= prod_d[PW-1:WIDTH];
            zero_q     <= (prod_d == '0);
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_hi   = out_hi_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : alu_seq
